// File: rtl/cla8_serial_word_adder.sv
// cla8_serial_word_adder
// Byte-serial front end for a multi-byte add built on an 8-bit carry-lookahead
// slice. Operand byte pairs arrive LSB first. Each accepted pair is summed with
// the registered inter-byte carry, and the byte sum goes to a one-deep output
// register.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, cin          begin a new addition (IDLE only) and its carry-in
//   in_valid/in_ready   input handshake for a_byte/b_byte
//   a_byte, b_byte      operand bytes, LSB first
//   out_valid/out_ready output handshake for sum_byte
//   sum_byte, out_last  sum byte and MS-byte marker
//   cout, ovf           carry out / signed overflow of the MS byte (valid with out_last)
//   busy, done          not-IDLE status, one-cycle completion pulse
module cla8_serial_word_adder #(
    parameter int NBYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cin,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a_byte,
    input  logic [7:0] b_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] sum_byte,
    output logic       out_last,
    output logic       cout,
    output logic       ovf,
    output logic       busy,
    output logic       done
);

    localparam int IDX_W = $clog2(NBYTES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       sum_q, sum_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [7:0] p, g, sum_c;
    logic [8:0] c;
    logic       accept, xfer, is_last;

    // Output register is the only buffer: a new pair may enter only if the
    // register is empty or draining this cycle.
    assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;
    assign is_last  = (idx_q == IDX_W'(NBYTES - 1));

    // Two-level lookahead: every carry is a sum of products taken directly from
    // p/g and carry_q, so no carry depends on another computed carry.
    always_comb begin
        logic prod;
        logic cc;
        p    = a_byte ^ b_byte;
        g    = a_byte & b_byte;
        c    = '0;
        c[0] = carry_q;
        prod = 1'b0;
        cc   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cc   = g[i];
            // carry-in propagated through p[i..0]
            prod = carry_q;
            for (int k = 0; k <= i; k++) prod = prod & p[k];
            cc = cc | prod;
            // g[j] propagated through p[i..j+1]
            for (int j = 0; j < i; j++) begin
                prod = g[j];
                for (int k = j + 1; k <= i; k++) prod = prod & p[k];
                cc = cc | prod;
            end
            c[i+1] = cc;
        end
        sum_c = p ^ c[7:0];
    end

    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    carry_d = c[8];
                    idx_d   = idx_q + 1'b1;
                    if (is_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (xfer) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A same-cycle accept reloads the register instead of emptying it.
        if (accept) begin
            sum_d       = sum_c;
            out_valid_d = 1'b1;
            out_last_d  = is_last;
            if (is_last) begin
                cout_d = c[8];
                ovf_d  = c[8] ^ c[7];
            end
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
        end
    end

    assign sum_byte  = sum_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cla8_serial_word_adder.sv
// Scoreboard bench for cla8_serial_word_adder (NBYTES=4). Stimulus pushes the
// hand-computed expected bytes; a negedge monitor pops on every output transfer.
module tb_cla8_serial_word_adder;

    logic       clk = 1'b0;
    logic       rst, start, cin, in_valid, out_ready;
    logic [7:0] a_byte, b_byte;
    logic       in_ready, out_valid, out_last, cout, ovf, busy, done;
    logic [7:0] sum_byte;

    cla8_serial_word_adder #(.NBYTES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .cin(cin),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_byte(a_byte), .b_byte(b_byte),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum_byte(sum_byte), .out_last(out_last),
        .cout(cout), .ovf(ovf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sum;
        logic       last;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   done_seen = 0;
    int   done_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected entry per transfer; also checks that done
    // pulses exactly the cycle after the MS byte transfer.
    initial begin
        exp_t e;
        logic prev_last_xfer;
        prev_last_xfer = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_last_xfer = 1'b0;
            end else begin
                if (prev_last_xfer || done) begin
                    chk("done_pulse", {31'b0, done}, {31'b0, prev_last_xfer});
                    if (done) chk("busy_at_done", {31'b0, busy}, 32'd0);
                end
                if (done) done_seen++;
                prev_last_xfer = 1'b0;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %0h, expected none", sum_byte);
                    end else begin
                        e = sb.pop_front();
                        chk("sum_byte", {24'b0, sum_byte}, {24'b0, e.sum});
                        chk("out_last", {31'b0, out_last}, {31'b0, e.last});
                        if (e.last) begin
                            chk("cout", {31'b0, cout}, {31'b0, e.cout});
                            chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
                        end
                    end
                    prev_last_xfer = out_last;
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] s, input logic co, input logic ov);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.sum  = s[8*k +: 8];
            e.last = (k == 3);
            e.cout = co;
            e.ovf  = ov;
            sb.push_back(e);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic send_byte(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        a_byte   = a;
        b_byte   = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c_in,
                          input logic [31:0] s, input logic co, input logic ov,
                          input bit hold);
        push_exp(s, co, ov);
        start = 1'b1;
        cin   = c_in;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8], b[8*k +: 8]);
        if (hold) begin
            // sit in DRAIN with start still high
            out_ready = 1'b0;
            repeat (2) begin
                @(negedge clk);
                chk("drain_busy", {31'b0, busy}, 32'd1);
                chk("drain_in_ready", {31'b0, in_ready}, 32'd0);
            end
            @(posedge clk);
            #1;
            start     = 1'b0;
            out_ready = 1'b1;
        end
        done_exp++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1, expected 0");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; cin = 1'b0; in_valid = 1'b0;
        a_byte = 8'h00; b_byte = 8'h00; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_sum", {24'b0, sum_byte}, 32'd0);
        chk("rst_last_cout_ovf", {29'b0, out_last, cout, ovf}, 32'd0);
        @(posedge clk);
        #1;

        // basic carry propagation
        run_op(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0);
        wait_idle();
        // full ripple with cin
        run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0);
        wait_idle();
        // signed overflow
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        wait_idle();
        // carry out and overflow together
        run_op(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0);
        wait_idle();

        // backpressure: stall 3 cycles after the first output
        fork
            run_op(32'h01020304, 32'h10203040, 1'b0, 32'h11223344, 1'b0, 1'b0, 1'b0);
            begin
                n = 0;
                @(posedge clk);
                #1;
                while (!out_valid && n < 20) begin
                    n++;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
                    chk("bp_sum_hold", {24'b0, sum_byte}, 32'h44);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_idle();

        // reset after two accepted bytes
        push_exp(32'h11223344, 1'b0, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_byte(8'h04, 8'h40);
        send_byte(8'h03, 8'h30);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("mid_rst_sum", {24'b0, sum_byte}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_last_cout_ovf", {29'b0, out_last, cout, ovf}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_op(32'h01020304, 32'h10203040, 1'b0, 32'h11223344, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // start held through RUN and DRAIN
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b1);
        wait_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("no_restart_busy", {31'b0, busy}, 32'd0);

        chk("done_count", done_seen, done_exp);
        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cla8_serial_word_adder.md
# cla8_serial_word_adder

Multi-byte adder front end for the 8-bit carry-lookahead datapath. Accepts wide operands as a stream of byte pairs, LSB first. For each pair it forms the 8-bit propagate/generate vectors, applies the registered inter-byte carry as the byte's carry-in, and emits one 8-bit sum per accepted pair. It owns the carry register that chains byte-level lookahead results into an NBYTES-wide addition, with valid/ready handshakes on both sides.

## Interface
- NBYTES, default 4: operand width in bytes; legal range 1..16.
- clk  in  1  rising-edge clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  begin a new addition; sampled only in IDLE.
- cin  in  1  carry into byte 0; latched when start is accepted.
- in_valid  in  1  a_byte/b_byte are valid.
- in_ready  out  1  block accepts a byte pair this cycle.
- a_byte  in  8  operand A byte, LSB first.
- b_byte  in  8  operand B byte, LSB first.
- out_valid  out  1  sum_byte is valid.
- out_ready  in  1  downstream accepts sum_byte.
- sum_byte  out  8  sum byte.
- out_last  out  1  sum_byte is the most significant byte.
- cout  out  1  carry out of the MS byte; meaningful only when out_last=1.
- ovf  out  1  signed overflow (c8 XOR c7 of the MS byte); meaningful only when out_last=1.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after the MS sum byte transfers.

## Operation
- **States: IDLE, RUN, DRAIN.**
- **IDLE:**
  - start=1 → carry_q := cin, idx := 0, go to RUN.
  - in_ready=0.
- **RUN:**
  - in_ready = !out_valid | out_ready.
  - A pair is accepted when in_valid & in_ready.
  - start is ignored.
- **Per accepted pair:**
  - p = a^b, g = a&b.
  - c0 = carry_q.
  - c[i+1] = g[i] | p[i]&g[i-1] | … | p[i]…p[0]&c0, computed in flattened two-level lookahead form, not ripple.
  - sum = p ^ c[7:0].
  - carry_q := c8, idx := idx+1.
- **Output register:** loads sum_byte, sets out_valid=1, and sets out_last = (idx==NBYTES-1).
  - On the last byte, cout and ovf are also loaded, and the state goes to DRAIN.
- **DRAIN:**
  - in_ready=0.
  - When out_valid & out_ready: out_valid := 0, done := 1 for one cycle, go to IDLE.
- **Output transfers (all states):** out_valid clears on out_valid & out_ready unless a new pair is accepted in the same cycle, in which case the register reloads.
- **Arithmetic:** modulo 2^(8·NBYTES). idx is a ceil(log2(NBYTES+1))-bit counter; it never wraps because the transition to DRAIN stops acceptance.
- **NBYTES=1:** the first accepted pair is also the last.
- **Reset:** state=IDLE, carry_q=0, idx=0, sum_byte=0x00, out_valid=0, out_last=0, cout=0, ovf=0, done=0, busy=0, in_ready=0.
- **rst mid-operation:** aborts immediately. Any pending output is dropped and no done pulse is produced.
- **start and in_valid together in IDLE:** the pair is not accepted in that cycle; it is accepted from the first RUN cycle.

## Timing
- **Latency:** pair accepted at edge N → sum_byte/out_valid visible after edge N (one register stage).
- **Throughput:** one byte per cycle while out_ready=1, giving NBYTES cycles from the first acceptance to the last acceptance.
- **Backpressure:** out_valid=1 & out_ready=0 forces in_ready=0 combinationally. sum_byte, out_last, cout and ovf hold stable until transfer.
- **done:** asserts the cycle after the MS byte transfer; busy deasserts in the same cycle as done.
- **Minimum restart:** start is accepted in the cycle done is high, since state is IDLE.
- **Combinational paths:**
  - The only input→output paths are out_ready→in_ready and the a/b → lookahead → output-register D path.
  - The carry path is register-to-register through carry_q only.

## Test plan
- **Basic carry propagation:** NBYTES=4, cin=0, A=0x000000FF, B=0x00000001, out_ready=1 → sum bytes 0x00, 0x01, 0x00, 0x00 on consecutive cycles; out_last on the 4th; cout=0, ovf=0; done one cycle later.
- **Full ripple with cin:** A=0xFFFFFFFF, B=0x00000000, cin=1 → all sum bytes 0x00, cout=1, ovf=0.
- **Signed overflow:** A=0x7FFFFFFF, B=0x00000001, cin=0 → bytes 0x00, 0x00, 0x00, 0x80; cout=0, ovf=1.
- **Backpressure:** hold out_ready=0 for 3 cycles after the first output → in_ready=0 and sum_byte held at its first value. Release → remaining bytes correct, no byte lost or duplicated.
- **Reset mid-operation:** assert rst after 2 bytes accepted → all outputs at reset values next cycle, no done pulse. A subsequent start with A=0x01020304, B=0x10203040 → 0x11223344.
- **Start while busy:** start=1 held during RUN and DRAIN → no restart, idx unaffected, result identical to a run with start pulsed once.
